// File: rtl/led_pattern_seq_if.sv
// Pattern sequencer bus: control levels toward the sequencer and the
// per-lane enable/phase/mode/step results toward the breathing stage.
//   next_i  : mode-advance request (level, debounced, synchronous)
//   pause_i : freezes pattern timing while high
//   en_o    : per-lane enable, bit i = lane i
//   phase_o : per-lane phase, bits [3i+2:3i] = lane i
//   mode_o  : 0 OFF, 1 BREATH, 2 CHASE, 3 WAVE
//   step_o  : one-cycle pulse on each pattern step
interface led_pattern_seq_if;
    localparam int unsigned LANES   = 8;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned MODE_W  = 2;

    logic                         next_i;
    logic                         pause_i;
    logic [LANES-1:0]             en_o;
    logic [LANES*PHASE_W-1:0]     phase_o;
    logic [MODE_W-1:0]            mode_o;
    logic                         step_o;

    modport master (
        output next_i,
        output pause_i,
        input  en_o,
        input  phase_o,
        input  mode_o,
        input  step_o
    );

    modport slave (
        input  next_i,
        input  pause_i,
        output en_o,
        output phase_o,
        output mode_o,
        output step_o
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: cycles OFF/BREATH/CHASE/WAVE on rising edges of
// next, time-steps chase/wave from a prescaled tick, and drives registered
// per-lane enables and 3-bit phases to the breathing stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : led_pattern_seq_if slave (next_i, pause_i in; en_o, phase_o,
//              mode_o, step_o out, all outputs registered)
module led_pattern_seq #(
    parameter int unsigned DIV        = 500000,
    parameter int unsigned STEP_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_seq_if.slave   bus
);
    localparam int unsigned LANES   = 8;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned STEP_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BREATH = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_WAVE   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    mode_e                    mode_q, mode_d;
    dir_e                     dir_q, dir_d;
    logic                     next_q;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [STEP_W-1:0]        step_cnt_q, step_cnt_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic [LANES-1:0]         en_q, en_d;
    logic [LANES*POS_W-1:0]   phase_q, phase_d;
    logic                     step_q, step_d;

    logic                     adv;
    logic                     tick;
    logic                     step_fire;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_OFF;
            dir_q      <= DIR_UP;
            next_q     <= 1'b0;
            div_q      <= '0;
            step_cnt_q <= '0;
            pos_q      <= '0;
            en_q       <= '0;
            phase_q    <= '0;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            next_q     <= bus.next_i;
            div_q      <= div_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            en_q       <= en_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
        end
    end

    // Next-state: prescaler, step counter, position walk, mode FSM, outputs
    always_comb begin
        mode_d     = mode_q;
        dir_d      = dir_q;
        div_d      = div_q;
        step_cnt_d = step_cnt_q;
        pos_d      = pos_q;
        en_d       = '0;
        phase_d    = '0;

        adv       = bus.next_i & ~next_q;
        tick      = ~bus.pause_i & (div_q == DIV_MAX);
        step_fire = tick & (step_cnt_q == STEP_MAX);

        if (!bus.pause_i) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (tick) begin
            step_cnt_d = step_fire ? '0 : step_cnt_q + STEP_W'(1);
        end

        if (step_fire) begin
            case (mode_q)
                MODE_CHASE: begin
                    // Ping-pong bounces off the end lanes without dwelling
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_W'(LANES - 1)) begin
                            pos_d = POS_W'(LANES - 2);
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_WAVE: pos_d = pos_q + POS_W'(1);
                default:   pos_d = pos_q;
            endcase
        end

        // A mode change restarts all pattern timing and overrides any step
        if (adv) begin
            case (mode_q)
                MODE_OFF:    mode_d = MODE_BREATH;
                MODE_BREATH: mode_d = MODE_CHASE;
                MODE_CHASE:  mode_d = MODE_WAVE;
                default:     mode_d = MODE_OFF;
            endcase
            div_d      = '0;
            step_cnt_d = '0;
            pos_d      = '0;
            dir_d      = DIR_UP;
        end

        step_d = step_fire & ~adv;

        // Outputs track the post-edge state
        case (mode_d)
            MODE_BREATH: en_d = '1;
            MODE_CHASE:  en_d = LANES'(1) << pos_d;
            MODE_WAVE: begin
                en_d = '1;
                for (int i = 0; i < LANES; i++) begin
                    phase_d[POS_W*i +: POS_W] = POS_W'(i) + pos_d;
                end
            end
            default:     en_d = '0;
        endcase
    end

    assign bus.mode_o  = mode_q;
    assign bus.en_o    = en_q;
    assign bus.phase_o = phase_q;
    assign bus.step_o  = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scenario bench for led_pattern_seq with DIV=4, STEP_TICKS=2 (one step
// every 8 clocks). Expected step results are queued and compared as the
// DUT produces each step_o pulse.
module tb_led_pattern_seq;
    localparam int unsigned DIV         = 4;
    localparam int unsigned STEP_TICKS  = 2;
    localparam int unsigned STEP_PERIOD = DIV * STEP_TICKS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_pattern_seq_if bus();

    led_pattern_seq #(.DIV(DIV), .STEP_TICKS(STEP_TICKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  en;
        logic [23:0] phase;
        logic [1:0]  mode;
        int          gap;
    } exp_t;

    exp_t sb[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until a step_o pulse is seen; gap = clock edges consumed
    task automatic wait_step(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 4 * STEP_PERIOD; i++) begin
            @(posedge clk);
            #1;
            gap++;
            if (bus.step_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_next();
        bus.next_i = 1'b1;
        cyc(1);
        bus.next_i = 1'b0;
    endtask

    function automatic logic [23:0] wave_phase(input int pos);
        logic [23:0] ph;
        ph = '0;
        for (int i = 0; i < 8; i++) ph[3*i +: 3] = 3'((i + pos) % 8);
        return ph;
    endfunction

    task automatic test_reset();
        int gap;
        bit ok;
        rst = 1'b1;
        bus.next_i  = 1'b0;
        bus.pause_i = 1'b0;
        cyc(3);
        rst = 1'b0;
        n_checks++;
        if (bus.en_o !== 8'h00 || bus.phase_o !== 24'h0 || bus.mode_o !== 2'd0 || bus.step_o !== 1'b0)
            $display("FAIL reset_state: en=%h phase=%h mode=%0d step=%b, expected all zero",
                     bus.en_o, bus.phase_o, bus.mode_o, bus.step_o);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            wait_step(gap, ok);
            n_checks++;
            if (!ok || gap != STEP_PERIOD || bus.en_o !== 8'h00 || bus.mode_o !== 2'd0)
                $display("FAIL off_step%0d: seen=%b gap=%0d en=%h mode=%0d, expected gap=%0d en=00 mode=0",
                         k, ok, gap, bus.en_o, bus.mode_o, STEP_PERIOD);
            else n_pass++;
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_modes [3];
        exp_modes[0] = 2'd2;
        exp_modes[1] = 2'd3;
        exp_modes[2] = 2'd0;
        bus.next_i = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.mode_o !== 2'd1 || bus.en_o !== 8'hFF || bus.phase_o !== 24'h0)
            $display("FAIL enter_breath: mode=%0d en=%h phase=%h, expected mode=1 en=ff phase=0",
                     bus.mode_o, bus.en_o, bus.phase_o);
        else n_pass++;
        cyc(9);
        n_checks++;
        if (bus.mode_o !== 2'd1)
            $display("FAIL held_next: mode=%0d, expected 1", bus.mode_o);
        else n_pass++;
        bus.next_i = 1'b0;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            pulse_next();
            n_checks++;
            if (bus.mode_o !== exp_modes[k])
                $display("FAIL mode_cycle%0d: mode=%0d, expected %0d", k, bus.mode_o, exp_modes[k]);
            else n_pass++;
            cyc(1);
        end
    endtask

    task automatic test_chase();
        logic [7:0] tbl [16];
        exp_t e;
        int gap;
        bit ok;
        tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        pulse_next();
        cyc(1);
        pulse_next();
        n_checks++;
        if (bus.mode_o !== 2'd2 || bus.en_o !== 8'h01 || bus.phase_o !== 24'h0)
            $display("FAIL enter_chase: mode=%0d en=%h phase=%h, expected mode=2 en=01 phase=0",
                     bus.mode_o, bus.en_o, bus.phase_o);
        else n_pass++;
        for (int k = 0; k < 16; k++) sb.push_back('{tbl[k], 24'h0, 2'd2, STEP_PERIOD});
        for (int k = 0; sb.size() > 0; k++) begin
            wait_step(gap, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || gap != e.gap || bus.en_o !== e.en || bus.phase_o !== e.phase || bus.mode_o !== e.mode)
                $display("FAIL chase_step%0d: seen=%b gap=%0d en=%h mode=%0d, expected gap=%0d en=%h mode=%0d",
                         k + 1, ok, gap, bus.en_o, bus.mode_o, e.gap, e.en, e.mode);
            else n_pass++;
        end
    endtask

    task automatic test_pause_and_adv();
        exp_t e;
        int gap;
        bit ok;
        bit frozen_ok;
        logic [23:0] ident;
        ident = wave_phase(0);
        frozen_ok = 1'b1;
        bus.pause_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            cyc(1);
            if (bus.step_o !== 1'b0 || bus.en_o !== 8'h04 || bus.mode_o !== 2'd2) frozen_ok = 1'b0;
        end
        n_checks++;
        if (!frozen_ok)
            $display("FAIL pause_freeze: en=%h step=%b at end, expected en=04 step=0 throughout",
                     bus.en_o, bus.step_o);
        else n_pass++;
        bus.pause_i = 1'b0;
        // Held prescaler means the first step lands a full period after release
        sb.push_back('{8'h08, 24'h0, 2'd2, STEP_PERIOD});
        wait_step(gap, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || gap != e.gap || bus.en_o !== e.en)
            $display("FAIL pause_resume: seen=%b gap=%0d en=%h, expected gap=%0d en=%h",
                     ok, gap, bus.en_o, e.gap, e.en);
        else n_pass++;
        cyc(STEP_PERIOD - 1);
        pulse_next();
        n_checks++;
        if (bus.mode_o !== 2'd3 || bus.step_o !== 1'b0 || bus.en_o !== 8'hFF || bus.phase_o !== ident)
            $display("FAIL adv_over_step: mode=%0d step=%b en=%h phase=%h, expected mode=3 step=0 en=ff phase=%h",
                     bus.mode_o, bus.step_o, bus.en_o, bus.phase_o, ident);
        else n_pass++;
    endtask

    task automatic test_wave();
        exp_t e;
        int gap;
        bit ok;
        for (int k = 1; k <= 8; k++) sb.push_back('{8'hFF, wave_phase(k), 2'd3, STEP_PERIOD});
        for (int k = 1; sb.size() > 0; k++) begin
            wait_step(gap, ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok || gap != e.gap || bus.en_o !== e.en || bus.phase_o !== e.phase || bus.mode_o !== e.mode)
                $display("FAIL wave_step%0d: seen=%b gap=%0d en=%h phase=%h, expected gap=%0d en=%h phase=%h",
                         k, ok, gap, bus.en_o, bus.phase_o, e.gap, e.en, e.phase);
            else n_pass++;
            if (k == 7) begin
                n_checks++;
                if (bus.phase_o[2:0] !== 3'd7 || bus.phase_o[5:3] !== 3'd0 || bus.phase_o[23:21] !== 3'd6)
                    $display("FAIL wave_pos7: lane0=%0d lane1=%0d lane7=%0d, expected 7 0 6",
                             bus.phase_o[2:0], bus.phase_o[5:3], bus.phase_o[23:21]);
                else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if (bus.phase_o[2:0] !== 3'd0 || bus.phase_o[23:21] !== 3'd7)
                    $display("FAIL wave_wrap: lane0=%0d lane7=%0d, expected 0 7",
                             bus.phase_o[2:0], bus.phase_o[23:21]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int gap;
        bit ok;
        bit all_ok;
        all_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_step(gap, ok);
            if (!ok) all_ok = 1'b0;
        end
        n_checks++;
        if (!all_ok || bus.phase_o[2:0] !== 3'd5 || bus.mode_o !== 2'd3)
            $display("FAIL wave_pos5: seen=%b lane0=%0d mode=%0d, expected steps seen lane0=5 mode=3",
                     all_ok, bus.phase_o[2:0], bus.mode_o);
        else n_pass++;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        n_checks++;
        if (bus.mode_o !== 2'd0 || bus.en_o !== 8'h00 || bus.phase_o !== 24'h0 || bus.step_o !== 1'b0)
            $display("FAIL mid_reset: mode=%0d en=%h phase=%h step=%b, expected all zero",
                     bus.mode_o, bus.en_o, bus.phase_o, bus.step_o);
        else n_pass++;
        cyc(1);
        pulse_next();
        n_checks++;
        if (bus.mode_o !== 2'd1 || bus.en_o !== 8'hFF || bus.phase_o !== 24'h0)
            $display("FAIL post_reset_breath: mode=%0d en=%h phase=%h, expected mode=1 en=ff phase=0",
                     bus.mode_o, bus.en_o, bus.phase_o);
        else n_pass++;
        wait_step(gap, ok);
        n_checks++;
        if (!ok || gap != STEP_PERIOD || bus.en_o !== 8'hFF || bus.phase_o !== 24'h0)
            $display("FAIL breath_step: seen=%b gap=%0d en=%h phase=%h, expected gap=%0d en=ff phase=0",
                     ok, gap, bus.en_o, bus.phase_o, STEP_PERIOD);
        else n_pass++;
    endtask

    initial begin
        bus.next_i  = 1'b0;
        bus.pause_i = 1'b0;
        test_reset();
        test_mode_cycle();
        test_chase();
        test_pause_and_adv();
        test_wave();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
